// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional memory timeout is enabled with the IFETCH_TIMEOUT_EN macro.
package ifetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ifetch_state_t;

endpackage

// File: rtl/toggle_edge_detect.sv
// Level-change detector for stage strobes: pulses for one cycle whenever
// the input differs from the value registered on the previous edge.
module toggle_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic level_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign pulse = level ^ level_prev;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: strobe toggle -> memory req/ack -> instruction register.
// Define IFETCH_TIMEOUT_EN to abort fetches after TIMEOUT cycles without mem_ack.
import ifetch_pkg::*;

module instr_fetch_unit #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               if_stage,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic               instr_valid,
    output logic               busy,
    output logic               overrun,
    output logic               fetch_err
);

    logic          fetch_req;
    ifetch_state_t state;
    logic          pend;
    logic [ADDR_W-1:0] pend_pc;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign fetch_err = 1'b0;
`endif

    toggle_edge_detect u_if_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (if_stage),
        .pulse   (fetch_req)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            pc_plus1    <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            pend        <= 1'b0;
            pend_pc     <= '0;
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= new_pc;
                        busy     <= 1'b1;
                        state    <= ST_REQ;
`ifdef IFETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                ST_REQ: begin
                    // A toggle during a fetch parks in the one-deep slot; latest wins.
                    if (fetch_req) begin
                        pend    <= 1'b1;
                        pend_pc <= new_pc;
                        if (pend) begin
                            overrun <= 1'b1;
                        end
                    end
                    if (mem_ack) begin
                        instr       <= mem_rdata;
                        instr_pc    <= mem_addr;
                        pc_plus1    <= mem_addr + 1'b1;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_DONE;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        instr       <= INSTR_W'(NOP_INSTR);
                        instr_pc    <= mem_addr;
                        pc_plus1    <= mem_addr + 1'b1;
                        fetch_err   <= 1'b1;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    instr_valid <= 1'b0;
                    if (fetch_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= new_pc;
                        pend     <= 1'b0;
                        state    <= ST_REQ;
                        if (pend) begin
                            overrun <= 1'b1;
                        end
`ifdef IFETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else if (pend) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pend_pc;
                        pend     <= 1'b0;
                        state    <= ST_REQ;
`ifdef IFETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit against a transaction-level
// model: one fetch in flight plus a latest-wins one-deep request slot.
module tb_instr_fetch_unit;

    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_stage = 1'b0;
    logic [7:0]  new_pc = 8'h00;
    logic        ack_en = 1'b0;
    logic        spur = 1'b0;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic [7:0]  pc_plus1;
    logic        instr_valid;
    logic        busy;
    logic        overrun;
    logic        fetch_err;

    logic [15:0] rom [256];

    assign mem_ack   = (mem_req & ack_en) | spur;
    assign mem_rdata = rom[mem_addr];

    always #5 clock = ~clock;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .new_pc      (new_pc),
        .if_stage    (if_stage),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus1    (pc_plus1),
        .instr_valid (instr_valid),
        .busy        (busy),
        .overrun     (overrun),
        .fetch_err   (fetch_err)
    );

    int total = 0;
    int bad = 0;

    // reference model state
    logic        m_prev;
    logic        m_out;
    logic        m_done;
    logic        m_slot_v;
    logic [7:0]  m_slot;
    logic [7:0]  m_addr;
    logic [15:0] m_instr;
    logic [7:0]  m_ipc;
    logic [7:0]  m_p1;
    logic        m_valid;
    logic        m_ovr;
    logic        m_err;
    int          m_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0; m_out = 1'b0; m_done = 1'b0; m_slot_v = 1'b0; m_slot = 8'h00;
        m_addr = 8'h00; m_instr = 16'h0000; m_ipc = 8'h00; m_p1 = 8'h00;
        m_valid = 1'b0; m_ovr = 1'b0; m_err = 1'b0; m_wait = 0;
    endtask

    task automatic model_issue(input logic [7:0] pc);
        m_out  = 1'b1;
        m_addr = pc;
        m_wait = 0;
    endtask

    task automatic model_complete(input logic [15:0] data, input bit err);
        m_instr = data;
        m_ipc   = m_addr;
        m_p1    = 8'((int'(m_addr) + 1) % 256);
        m_valid = 1'b1;
        m_out   = 1'b0;
        m_done  = 1'b1;
        if (err) m_err = 1'b1;
        $display("fetch pc=%02h instr=%04h err=%0d", m_ipc, m_instr, err);
    endtask

    task automatic model_step();
        bit t;
        t = (if_stage != m_prev);
        m_prev = if_stage;
        m_valid = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
            if (t) begin
                if (m_slot_v) m_ovr = 1'b1;
                m_slot_v = 1'b0;
                model_issue(new_pc);
            end else if (m_slot_v) begin
                m_slot_v = 1'b0;
                model_issue(m_slot);
            end
        end else if (m_out) begin
            if (t) begin
                if (m_slot_v) m_ovr = 1'b1;
                m_slot_v = 1'b1;
                m_slot = new_pc;
            end
            if (ack_en) begin
                model_complete(rom[m_addr], 1'b0);
            end else begin
                m_wait++;
`ifdef IFETCH_TIMEOUT_EN
                if (m_wait == TO) model_complete(16'h0000, 1'b1);
`endif
            end
        end else if (t) begin
            model_issue(new_pc);
        end
    endtask

    task automatic compare_all();
        check("mem_req", mem_req, m_out);
        check("mem_addr", mem_addr, m_addr);
        check("instr_valid", instr_valid, m_valid);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("pc_plus1", pc_plus1, m_p1);
        check("busy", busy, m_out | m_done);
        check("overrun", overrun, m_ovr);
        check("fetch_err", fetch_err, m_err);
    endtask

    // called at a negedge; drives inputs, advances model at posedge, checks at negedge
    task automatic step(input bit tog, input logic [7:0] pc, input bit ack, input bit sp);
        if (tog) if_stage = ~if_stage;
        new_pc = pc;
        ack_en = ack;
        spur   = sp;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'h10] = 16'hA5A5;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        compare_all();
        check("rst_instr", instr, 16'h0000);

        // zero-wait fetch
        step(1, 8'h10, 1, 0);
        check("t1_mem_addr", mem_addr, 8'h10);
        step(0, 8'h00, 1, 0);
        check("t1_instr", instr, 16'hA5A5);
        check("t1_valid", instr_valid, 1'b1);
        check("t1_pc_plus1", pc_plus1, 8'h11);
        step(0, 8'h00, 1, 0);
        check("t1_valid_drop", instr_valid, 1'b0);

        // address wrap
        step(1, 8'hFF, 1, 0);
        step(0, 8'h00, 1, 0);
        check("t2_pc_plus1", pc_plus1, 8'h00);
        check("t2_instr_pc", instr_pc, 8'hFF);
        step(0, 8'h00, 1, 0);

        // 3 wait states, second toggle during REQ
        step(1, 8'h20, 0, 0);
        step(1, 8'h21, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        check("t3_mem_addr", mem_addr, 8'h21);
        check("t3_mem_req", mem_req, 1'b1);
        check("t3_overrun", overrun, 1'b0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // three toggles during one slow fetch
        step(1, 8'h30, 0, 0);
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        check("t4_first_pc", instr_pc, 8'h30);
        step(0, 8'h00, 1, 0);
        check("t4_mem_addr", mem_addr, 8'h32);
        check("t4_overrun", overrun, 1'b1);
        step(0, 8'h00, 1, 0);
        check("t4_second_pc", instr_pc, 8'h32);
        step(0, 8'h00, 0, 0);

        // memory never acknowledges
        step(1, 8'h40, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 0);
`ifdef IFETCH_TIMEOUT_EN
        check("t5_fetch_err", fetch_err, 1'b1);
        check("t5_instr_nop", instr, 16'h0000);
        check("t5_mem_req", mem_req, 1'b0);
`else
        check("t5_mem_req", mem_req, 1'b1);
        check("t5_fetch_err", fetch_err, 1'b0);
`endif

        // reset in the middle of a fetch
        step(1, 8'h41, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_mem_req_async", mem_req, 1'b0);
        check("t6_busy", busy, 1'b0);
        model_reset();
        if_stage = 1'b0;
        ack_en = 1'b1;
        spur = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1);
        check("t6_instr", instr, 16'h0000);
        check("t6_valid", instr_valid, 1'b0);

        // one toggle per 5 cycles never overruns
        for (int i = 0; i < 8; i++) begin
            step(1, 8'($urandom), 1, 0);
            for (int j = 0; j < 4; j++) step(0, 8'h00, 1, 0);
        end
        check("t7_no_overrun", overrun, 1'b0);

        // toggles on every edge
        for (int i = 0; i < 12; i++) step(1, 8'($urandom), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // random traffic with random wait states and stray acks
        for (int i = 0; i < 400; i++) begin
            bit tog;
            bit ack;
            bit sp;
            tog = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 1) == 1);
            sp  = !m_out && ($urandom_range(0, 3) == 0);
            step(tog, 8'($urandom), ack, sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage directly downstream of the program counter. It detects each toggle of the PC block's `if_stage` strobe, fetches the instruction word at `new_pc` from instruction memory over a req/ack handshake, and holds it in an instruction register for decode. It also returns `pc_plus1` to the PC block's `current_pc` input, which closes the sequential-fetch loop.

## Interface
- `ADDR_W`, default 8: PC / memory address width.
- `INSTR_W`, default 16: instruction word width.
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ack` (used only with the timeout feature).
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `new_pc`  in  ADDR_W: fetch address from the PC block.
- `if_stage`  in  1: fetch strobe; every level change (either direction) requests one fetch.
- `mem_req`  out  1: memory request, registered.
- `mem_addr`  out  ADDR_W: memory address, registered; stable while `mem_req`=1.
- `mem_ack`  in  1: memory data valid.
- `mem_rdata`  in  INSTR_W: instruction word, sampled when `mem_ack`=1.
- `instr`  out  INSTR_W: instruction register.
- `instr_pc`  out  ADDR_W: address of the word held in `instr`.
- `pc_plus1`  out  ADDR_W: `instr_pc`+1 mod 2^ADDR_W; feeds `current_pc`.
- `instr_valid`  out  1: one-cycle pulse when a new `instr` is loaded.
- `busy`  out  1: high in REQ or DONE.
- `overrun`  out  1: sticky; a request was lost.
- `fetch_err`  out  1: sticky; a memory timeout occurred. Tied 0 without the timeout feature.

## Operation
- The edge detector registers `if_prev`, which resets to 0. A request is raised on any edge where `if_stage != if_prev`. On that edge `new_pc` is captured.
- FSM states:
  - IDLE: on a request, `mem_addr`←`new_pc`, `mem_req`←1, go to REQ.
  - REQ: hold `mem_req` and `mem_addr`. On `mem_ack`=1:
    - `instr`←`mem_rdata`, `instr_pc`←`mem_addr`, `pc_plus1`←`mem_addr`+1 (wraps 0xFF→0x00).
    - `mem_req`←0, `instr_valid`←1, go to DONE.
  - DONE: `instr_valid`←0. If a pending or new request exists, issue it (as in IDLE) and go to REQ; otherwise go to IDLE.
- One-deep pending slot. A request arriving in REQ sets `pend` and stores its PC in `pend_pc`.
- If a request arrives while `pend`=1, the newer PC overwrites `pend_pc` and `overrun`←1.
- A request arriving in DONE is issued immediately, with no pending slot used. If `pend` is also set, the new request wins and `overrun`←1.
- `overrun` and `fetch_err` clear only on reset.
- `instr`, `instr_pc` and `pc_plus1` hold their values between fetches.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_pc`=0, `pc_plus1`=0, `instr_valid`=0, `busy`=0, `overrun`=0, `fetch_err`=0; state IDLE, `pend`=0, `if_prev`=0.
- Reset asserted mid-fetch: `mem_req` drops asynchronously. The in-flight fetch is discarded, and any `mem_ack` after reset is ignored.
- Latency with zero-wait memory (`mem_ack` combinational on `mem_req`):
  - edge E0 detects the toggle;
  - edge E1 samples `mem_ack`;
  - `instr_valid` is high from E1 to E2.
- Each memory wait state adds one cycle.
- Back-to-back toggles on every edge sustain at most one fetch per 2 cycles. Slower toggles, e.g. one per 5 cycles from the PC block, never overrun.
- `mem_ack` seen outside REQ is ignored.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - A wait counter clears on entry to REQ and increments each REQ cycle without `mem_ack`.
  - When the counter reaches `TIMEOUT`: `instr`←`NOP_INSTR`, `instr_pc`←`mem_addr`, `pc_plus1`←`mem_addr`+1, `fetch_err`←1, `instr_valid`←1, `mem_req`←0, go to DONE.
- `IFETCH_TIMEOUT_EN` undefined: REQ waits indefinitely, there is no counter, and `fetch_err` is constant 0.

## Structure
- Package `ifetch_pkg` holds:
  - the FSM state enum (IDLE, REQ, DONE);
  - `NOP_INSTR` (all zeros);
  - default widths.
- Sub-module `toggle_edge_detect` (registered previous value with async active-low reset; pulse output) is the natural split. It is reusable for the other stage strobes.

## Test plan
- Reset, then toggle `if_stage` 0→1 with `new_pc`=0x10, zero-wait memory returning 0xA5A5 → `mem_addr`=0x10; `instr`=0xA5A5 and `instr_valid` pulse at E1–E2; `pc_plus1`=0x11.
- `new_pc`=0xFF fetch → `pc_plus1`=0x00; `instr_pc`=0xFF.
- Memory with 3 wait states, second toggle (PC 0x21) during REQ → second fetch issued from DONE with `mem_addr`=0x21; `overrun`=0.
- Three toggles (PCs 0x30, 0x31, 0x32) during one slow fetch → fetches 0x30 then 0x32; `overrun`=1.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT`=15, `mem_ack` held 0 → after 15 REQ cycles `instr`=0x0000, `fetch_err`=1, `mem_req`=0. Without the macro, `mem_req` stays 1 and `fetch_err`=0.
- `reset_n` pulsed low during REQ → `mem_req`=0 immediately; a later `mem_ack` leaves `instr`=0 and `instr_valid`=0.
